// File: rtl/dist_pkg.sv
// rtl/dist_pkg.sv - shared range constants and FSM state type for the ultrasonic distance path
// Used by the echo-timing stage, dist_haptic_map and the APB wrapper.
package dist_pkg;
    localparam int DIST_W        = 16;
    localparam int DUTY_W        = 8;
    localparam int CYCLES_PER_CM = 5882;
    localparam int MAX_CM        = 400;

    // Echo widths above this are reported as MAX_CM with out_of_range set.
    localparam logic [31:0] MAX_ECHO_CYCLES = 32'(MAX_CM * CYCLES_PER_CM);

    typedef enum logic [2:0] {
        IDLE,
        DIV_DIST,
        AVG,
        DIV_DUTY,
        DONE
    } state_t;

    // How the duty target is produced once the divide for it finishes.
    typedef enum logic [1:0] {
        TGT_DIV,
        TGT_FULL,
        TGT_ZERO
    } duty_sel_t;
endpackage

// File: rtl/dist_haptic_map_if.sv
// rtl/dist_haptic_map_if.sv - echo input and distance/haptic output bundle
// slave : the dist_haptic_map side (echo in; busy, distance, status, PWM out)
// master: the producer/consumer side (echo out; everything else in)
interface dist_haptic_map_if;
    import dist_pkg::*;

    logic [31:0]       echo_cycles;
    logic              echo_valid;
    logic              busy;
    logic [DIST_W-1:0] dist_cm;
    logic              dist_valid;
    logic [DIST_W-1:0] avg_cm;
    logic              out_of_range;
    logic [DUTY_W-1:0] duty;
    logic              motor_pwm;
    logic [7:0]        drop_count;

    modport slave (
        input  echo_cycles, echo_valid,
        output busy, dist_cm, dist_valid, avg_cm, out_of_range, duty, motor_pwm, drop_count
    );

    modport master (
        output echo_cycles, echo_valid,
        input  busy, dist_cm, dist_valid, avg_cm, out_of_range, duty, motor_pwm, drop_count
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 32-bit unsigned restoring divider, one quotient bit per clock
// clk, rst_n          : clock, asynchronous active-low reset
// i_start             : load operands; iterations run on the following 32 edges
// i_dividend/i_divisor: operands, sampled with i_start
// o_done              : high during the cycle whose closing edge performs the last iteration
// o_quotient          : valid from the cycle after o_done; divide-by-zero gives all ones
module seq_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_done,
    output logic [31:0] o_quotient
);
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_den;
    logic [4:0]  r_cnt;
    logic        r_running;

    logic [32:0] w_partial;
    logic [32:0] w_trial;

    // The dividend shifts out of r_quo MSB-first while quotient bits shift in at the LSB.
    assign w_partial  = {r_rem, r_quo[31]};
    assign w_trial    = w_partial - {1'b0, r_den};
    assign o_done     = r_running && (r_cnt == 5'd31);
    assign o_quotient = r_quo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_den     <= '0;
            r_cnt     <= '0;
            r_running <= 1'b0;
        end else if (i_start) begin
            r_rem     <= '0;
            r_quo     <= i_dividend;
            r_den     <= i_divisor;
            r_cnt     <= '0;
            r_running <= 1'b1;
        end else if (r_running) begin
            // A zero divisor never borrows, so every quotient bit comes out as 1.
            if (!w_trial[32]) begin
                r_rem <= w_trial[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end else begin
                r_rem <= w_partial[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_running <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/dist_haptic_map.sv
// rtl/dist_haptic_map.sv - echo width to cm, moving average, and distance-to-haptic PWM mapping
// PCLK, PRESERN : clock, asynchronous active-low reset
// bus (slave)   : echo_cycles/echo_valid in; busy, dist_cm, dist_valid, avg_cm,
//                 out_of_range, duty, motor_pwm, drop_count out
module dist_haptic_map
    import dist_pkg::*;
#(
    parameter int NEAR_CM  = 20,
    parameter int FAR_CM   = 200,
    parameter int AVG_LOG2 = 2,
    parameter int PWM_DIV  = 391
) (
    input  logic              PCLK,
    input  logic              PRESERN,
    dist_haptic_map_if.slave  bus
);
    localparam int          DEPTH     = 1 << AVG_LOG2;
    localparam int          SUM_W     = DIST_W + AVG_LOG2;
    localparam logic [15:0] NEAR_W    = 16'(NEAR_CM);
    localparam logic [15:0] FAR_W     = 16'(FAR_CM);
    localparam logic [31:0] DUTY_SPAN = 32'(FAR_CM - NEAR_CM);
    localparam logic [15:0] PRE_LAST  = 16'(PWM_DIV - 1);

    state_t              r_state;
    logic                r_busy;
    logic                r_oor_pend;
    logic [DIST_W-1:0]   r_dist;
    logic                r_dist_valid;
    logic [DIST_W-1:0]   r_avg;
    logic                r_oor;
    logic [DIST_W-1:0]   r_ring [0:DEPTH-1];
    logic [AVG_LOG2-1:0] r_wptr;
    logic [SUM_W-1:0]    r_sum;
    logic                r_ring_valid;
    duty_sel_t           r_tgt_mode;
    logic [DUTY_W-1:0]   r_duty_pending;
    logic [7:0]          r_drop;
    logic [15:0]         r_pre;
    logic [7:0]          r_pwm_cnt;
    logic [DUTY_W-1:0]   r_duty;
    logic                r_pwm;

    logic                w_div_start;
    logic [31:0]         w_div_dividend;
    logic [31:0]         w_div_divisor;
    logic                w_div_done;
    logic [31:0]         w_div_q;
    logic                w_unused_q;
    logic [DIST_W-1:0]   w_dist;
    logic [SUM_W-1:0]    w_sum_next;
    logic [DIST_W-1:0]   w_avg_next;
    logic [15:0]         w_gap;
    logic [31:0]         w_duty_num;
    logic                w_pwm_step;

    // One divider serves both divides: echo/CYCLES_PER_CM from IDLE, then the duty scale from AVG.
    // Out-of-range and saturated-duty cases still run it so the latency never varies.
    assign w_div_start    = ((r_state == IDLE) && bus.echo_valid) || (r_state == AVG);
    assign w_div_dividend = (r_state == AVG) ? w_duty_num : bus.echo_cycles;
    assign w_div_divisor  = (r_state == AVG) ? DUTY_SPAN : 32'(CYCLES_PER_CM);

    seq_divider u_div (
        .clk        (PCLK),
        .rst_n      (PRESERN),
        .i_start    (w_div_start),
        .i_dividend (w_div_dividend),
        .i_divisor  (w_div_divisor),
        .o_done     (w_div_done),
        .o_quotient (w_div_q)
    );

    // In-range quotients are at most MAX_CM, so the upper half is always zero.
    assign w_unused_q = ^w_div_q[31:16];

    assign w_dist     = r_oor_pend ? DIST_W'(MAX_CM) : w_div_q[DIST_W-1:0];
    // The first sample after reset fills the whole window, so there is no ramp-up from zero.
    assign w_sum_next = r_ring_valid
                      ? (r_sum - SUM_W'(r_ring[r_wptr]) + SUM_W'(w_dist))
                      : (SUM_W'(w_dist) << AVG_LOG2);
    assign w_avg_next = w_sum_next[AVG_LOG2 +: DIST_W];
    // Only meaningful for NEAR_CM < avg < FAR_CM; other cases are overridden in DONE.
    assign w_gap      = FAR_W - w_avg_next;
    assign w_duty_num = {16'd0, w_gap} * 32'd255;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_oor_pend     <= 1'b0;
            r_dist         <= '0;
            r_dist_valid   <= 1'b0;
            r_avg          <= '0;
            r_oor          <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ring[i] <= '0;
            end
            r_wptr         <= '0;
            r_sum          <= '0;
            r_ring_valid   <= 1'b0;
            r_tgt_mode     <= TGT_ZERO;
            r_duty_pending <= '0;
            r_drop         <= '0;
        end else begin
            r_dist_valid <= 1'b0;
            r_busy       <= (r_state != IDLE);

            if (bus.echo_valid && (r_state != IDLE) && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.echo_valid) begin
                        r_oor_pend <= (bus.echo_cycles > MAX_ECHO_CYCLES);
                        r_state    <= DIV_DIST;
                    end
                end
                DIV_DIST: begin
                    if (w_div_done) begin
                        r_state <= AVG;
                    end
                end
                AVG: begin
                    r_dist       <= w_dist;
                    r_dist_valid <= 1'b1;
                    r_oor        <= r_oor_pend;
                    r_sum        <= w_sum_next;
                    r_avg        <= w_avg_next;
                    if (r_ring_valid) begin
                        r_ring[r_wptr] <= w_dist;
                        r_wptr         <= r_wptr + 1'b1;
                    end else begin
                        for (int i = 0; i < DEPTH; i++) begin
                            r_ring[i] <= w_dist;
                        end
                        r_ring_valid <= 1'b1;
                    end
                    if (r_oor_pend) begin
                        r_tgt_mode <= TGT_ZERO;
                    end else if (w_avg_next <= NEAR_W) begin
                        r_tgt_mode <= TGT_FULL;
                    end else if (w_avg_next >= FAR_W) begin
                        r_tgt_mode <= TGT_ZERO;
                    end else begin
                        r_tgt_mode <= TGT_DIV;
                    end
                    r_state <= DIV_DUTY;
                end
                DIV_DUTY: begin
                    if (w_div_done) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    case (r_tgt_mode)
                        TGT_FULL: r_duty_pending <= 8'hFF;
                        TGT_DIV:  r_duty_pending <= w_div_q[DUTY_W-1:0];
                        default:  r_duty_pending <= 8'h00;
                    endcase
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_pwm_step = (r_pre == PRE_LAST);

    // The active duty only changes on the 255->0 counter wrap, so every period is whole.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_pre     <= '0;
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_pwm <= (r_pwm_cnt < r_duty);
            if (w_pwm_step) begin
                r_pre     <= '0;
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
                if (r_pwm_cnt == 8'hFF) begin
                    r_duty <= r_duty_pending;
                end
            end else begin
                r_pre <= r_pre + 16'd1;
            end
        end
    end

    assign bus.busy         = r_busy;
    assign bus.dist_cm      = r_dist;
    assign bus.dist_valid   = r_dist_valid;
    assign bus.avg_cm       = r_avg;
    assign bus.out_of_range = r_oor;
    assign bus.duty         = r_duty;
    assign bus.motor_pwm    = r_pwm;
    assign bus.drop_count   = r_drop;
endmodule

// File: tb/tb_dist_haptic_map.sv
// tb/tb_dist_haptic_map.sv - directed self-checking bench for dist_haptic_map
module tb_dist_haptic_map;
    localparam int PWM_DIV = 2;
    localparam int PERIOD  = 256 * PWM_DIV;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int errors = 0;
    int checks = 0;

    dist_haptic_map_if bus();

    dist_haptic_map #(.PWM_DIV(PWM_DIV)) dut (
        .PCLK    (clk),
        .PRESERN (rstn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [15:0] ob_dist, ob_avg;
    logic        ob_dv_pre, ob_dv, ob_dv_post, ob_oor, ob_busy1, ob_busy66, ob_busy67;

    task automatic do_reset();
        rstn = 1'b0;
        bus.echo_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Drives one sample (edge t) and records outputs after edges t+k; optional second strobe at t+extra_at.
    task automatic send_sample(input logic [31:0] echo, input int extra_at, input logic [31:0] extra_echo);
        @(negedge clk);
        bus.echo_cycles = echo;
        bus.echo_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.echo_valid = 1'b0;
        for (int k = 1; k <= 67; k++) begin
            if (k == extra_at) begin
                bus.echo_cycles = extra_echo;
                bus.echo_valid  = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.echo_valid = 1'b0;
            if (k == 1)  ob_busy1 = bus.busy;
            if (k == 32) ob_dv_pre = bus.dist_valid;
            if (k == 33) begin
                ob_dv   = bus.dist_valid;
                ob_dist = bus.dist_cm;
                ob_avg  = bus.avg_cm;
                ob_oor  = bus.out_of_range;
            end
            if (k == 34) ob_dv_post = bus.dist_valid;
            if (k == 66) ob_busy66 = bus.busy;
            if (k == 67) ob_busy67 = bus.busy;
        end
    endtask

    task automatic wait_duty(input logic [7:0] target, output int waited);
        waited = 0;
        while (bus.duty !== target && waited < 1200) begin
            @(posedge clk);
            #1;
            waited++;
        end
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.motor_pwm === 1'b1) hi++;
        end
    endtask

    task automatic test_reset();
        logic [59:0] v;
        rstn = 1'b0;
        bus.echo_valid  = 1'b0;
        bus.echo_cycles = 32'd0;
        #1;
        v = {bus.busy, bus.dist_cm, bus.dist_valid, bus.avg_cm, bus.out_of_range, bus.duty, bus.motor_pwm, bus.drop_count};
        checks++;
        if (v !== 60'd0) begin errors++; $display("FAIL reset_in outputs got %h want 0", v); end
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        v = {bus.busy, bus.dist_cm, bus.dist_valid, bus.avg_cm, bus.out_of_range, bus.duty, bus.motor_pwm, bus.drop_count};
        checks++;
        if (v !== 60'd0) begin errors++; $display("FAIL reset_after outputs got %h want 0", v); end
    endtask

    task automatic test_10cm();
        int w, hi;
        do_reset();
        send_sample(32'd58820, 0, 32'd0);
        checks++; if (ob_busy1 !== 1'b1) begin errors++; $display("FAIL 10cm busy_t1 got %b want 1", ob_busy1); end
        checks++; if (ob_dv_pre !== 1'b0) begin errors++; $display("FAIL 10cm dv_t32 got %b want 0", ob_dv_pre); end
        checks++; if (ob_dv !== 1'b1) begin errors++; $display("FAIL 10cm dv_t33 got %b want 1", ob_dv); end
        checks++; if (ob_dv_post !== 1'b0) begin errors++; $display("FAIL 10cm dv_t34 got %b want 0", ob_dv_post); end
        checks++; if (ob_dist !== 16'd10) begin errors++; $display("FAIL 10cm dist got %0d want 10", ob_dist); end
        checks++; if (ob_avg !== 16'd10) begin errors++; $display("FAIL 10cm avg got %0d want 10", ob_avg); end
        checks++; if (ob_oor !== 1'b0) begin errors++; $display("FAIL 10cm oor got %b want 0", ob_oor); end
        wait_duty(8'd255, w);
        checks++; if (bus.duty !== 8'd255) begin errors++; $display("FAIL 10cm duty got %0d want 255", bus.duty); end
        count_high(PERIOD, hi);
        checks++; if (hi !== 255 * PWM_DIV) begin errors++; $display("FAIL 10cm pwm_high got %0d want %0d", hi, 255 * PWM_DIV); end
    endtask

    task automatic test_100cm();
        int w, hi;
        do_reset();
        send_sample(32'd588200, 0, 32'd0);
        checks++; if (ob_dist !== 16'd100) begin errors++; $display("FAIL 100cm dist got %0d want 100", ob_dist); end
        checks++; if (ob_avg !== 16'd100) begin errors++; $display("FAIL 100cm avg got %0d want 100", ob_avg); end
        checks++; if (ob_busy66 !== 1'b1) begin errors++; $display("FAIL 100cm busy_t66 got %b want 1", ob_busy66); end
        checks++; if (ob_busy67 !== 1'b0) begin errors++; $display("FAIL 100cm busy_t67 got %b want 0", ob_busy67); end
        wait_duty(8'd141, w);
        checks++; if (bus.duty !== 8'd141) begin errors++; $display("FAIL 100cm duty got %0d want 141", bus.duty); end
        count_high(PERIOD, hi);
        checks++; if (hi !== 141 * PWM_DIV) begin errors++; $display("FAIL 100cm pwm_high got %0d want %0d", hi, 141 * PWM_DIV); end
    endtask

    // Continues from the 100 cm state: ring holds four 100 cm entries.
    task automatic test_out_of_range();
        int w, hi;
        send_sample(32'd2400000, 0, 32'd0);
        checks++; if (ob_dist !== 16'd400) begin errors++; $display("FAIL oor dist got %0d want 400", ob_dist); end
        checks++; if (ob_oor !== 1'b1) begin errors++; $display("FAIL oor flag got %b want 1", ob_oor); end
        checks++; if (ob_avg !== 16'd175) begin errors++; $display("FAIL oor avg got %0d want 175", ob_avg); end
        wait_duty(8'd0, w);
        checks++; if (bus.duty !== 8'd0) begin errors++; $display("FAIL oor duty got %0d want 0", bus.duty); end
        count_high(PERIOD, hi);
        checks++; if (hi !== 0) begin errors++; $display("FAIL oor pwm_high got %0d want 0", hi); end
        send_sample(32'd588200, 0, 32'd0);
        checks++; if (ob_oor !== 1'b0) begin errors++; $display("FAIL oor_clear flag got %b want 0", ob_oor); end
        checks++; if (ob_dist !== 16'd100) begin errors++; $display("FAIL oor_clear dist got %0d want 100", ob_dist); end
        wait_duty(8'd35, w);
        checks++; if (bus.duty !== 8'd35) begin errors++; $display("FAIL oor_clear duty got %0d want 35", bus.duty); end
    endtask

    task automatic test_averaging();
        int w;
        logic [15:0] exp_avg [0:2] = '{16'd60, 16'd40, 16'd20};
        do_reset();
        send_sample(32'd588200, 0, 32'd0);
        checks++; if (ob_avg !== 16'd100) begin errors++; $display("FAIL avg preload got %0d want 100", ob_avg); end
        send_sample(32'd117640, 0, 32'd0);
        checks++; if (ob_dist !== 16'd20) begin errors++; $display("FAIL avg s1 dist got %0d want 20", ob_dist); end
        checks++; if (ob_avg !== 16'd80) begin errors++; $display("FAIL avg s1 avg got %0d want 80", ob_avg); end
        wait_duty(8'd170, w);
        checks++; if (bus.duty !== 8'd170) begin errors++; $display("FAIL avg s1 duty got %0d want 170", bus.duty); end
        for (int i = 0; i < 3; i++) begin
            send_sample(32'd117640, 0, 32'd0);
            checks++;
            if (ob_avg !== exp_avg[i]) begin errors++; $display("FAIL avg s%0d avg got %0d want %0d", i + 2, ob_avg, exp_avg[i]); end
        end
        wait_duty(8'd255, w);
        checks++; if (bus.duty !== 8'd255) begin errors++; $display("FAIL avg final duty got %0d want 255", bus.duty); end
    endtask

    task automatic test_overrun();
        do_reset();
        send_sample(32'd588200, 10, 32'd117640);
        checks++; if (ob_dist !== 16'd100) begin errors++; $display("FAIL overrun dist got %0d want 100", ob_dist); end
        checks++; if (ob_avg !== 16'd100) begin errors++; $display("FAIL overrun avg got %0d want 100", ob_avg); end
        checks++; if (bus.drop_count !== 8'd1) begin errors++; $display("FAIL overrun drops got %0d want 1", bus.drop_count); end
        @(negedge clk);
        bus.echo_cycles = 32'd588200;
        bus.echo_valid  = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk);
        bus.echo_valid = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        checks++; if (bus.drop_count !== 8'd255) begin errors++; $display("FAIL overrun_sat drops got %0d want 255", bus.drop_count); end
    endtask

    task automatic test_reset_mid();
        logic [59:0] v;
        int waited, stray;
        do_reset();
        send_sample(32'd1176400, 0, 32'd0);
        checks++; if (ob_avg !== 16'd200) begin errors++; $display("FAIL rmid pre avg got %0d want 200", ob_avg); end
        @(negedge clk);
        bus.echo_cycles = 32'd117640;
        bus.echo_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.echo_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        v = {bus.busy, bus.dist_cm, bus.dist_valid, bus.avg_cm, bus.out_of_range, bus.duty, bus.motor_pwm, bus.drop_count};
        checks++; if (v !== 60'd0) begin errors++; $display("FAIL rmid outputs got %h want 0", v); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        send_sample(32'd588200, 0, 32'd0);
        checks++; if (ob_avg !== 16'd100) begin errors++; $display("FAIL rmid post avg got %0d want 100", ob_avg); end
        checks++; if (bus.duty !== 8'd0) begin errors++; $display("FAIL rmid duty_before_wrap got %0d want 0", bus.duty); end
        waited = 0;
        stray  = 0;
        while (bus.duty !== 8'd141 && waited < 1200) begin
            @(posedge clk);
            #1;
            waited++;
            if (bus.duty !== 8'd141 && bus.motor_pwm !== 1'b0) stray++;
        end
        checks++; if (bus.duty !== 8'd141) begin errors++; $display("FAIL rmid duty_after_wrap got %0d want 141", bus.duty); end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rmid early_pwm got %0d cycles want 0", stray); end
        @(posedge clk);
        #1;
        checks++; if (bus.motor_pwm !== 1'b1) begin errors++; $display("FAIL rmid pwm_on got %b want 1", bus.motor_pwm); end
    endtask

    initial begin
        bus.echo_valid  = 1'b0;
        bus.echo_cycles = 32'd0;
        test_reset();
        test_10cm();
        test_100cm();
        test_out_of_range();
        test_averaging();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
